// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// stream framing sizes.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects little-endian bytes into a 32-bit word; word_ready flags the byte
// that completes a word, with word_full already holding the complete word.
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        word_ready,
  output logic [8*BYTES_PER_WORD-1:0] word_full
);

  localparam int                IDX_W    = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]                byte_idx;
  logic [8*(BYTES_PER_WORD-1)-1:0] shift_q;

  // Earlier bytes shift down so the first byte of the word lands in bits 7:0.
  assign word_ready = byte_valid && (byte_idx == LAST_IDX);
  assign word_full  = {byte_data, shift_q};

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      byte_idx <= '0;
    end else if (byte_valid) begin
      byte_idx <= byte_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) begin
      shift_q <= {byte_data, shift_q[8*(BYTES_PER_WORD-1)-1:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction memory writer: parses a 16-bit LE word count and LE words
// from a byte stream. Define PROGRAM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_byte_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  loader_state_t            state, state_nxt, tail_state;
  logic [8*HDR_BYTES-1:0]   count, len;
  logic [15:0]              word_idx;
  logic                     accept, word_ready;
  logic [31:0]              word_full;
  logic                     rx_ready_nxt, we_nxt, hold_nxt, done_nxt, error_nxt;

  assign accept = rx_valid && rx_ready;
  assign len    = {rx_data, count[7:0]};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign tail_state = CHK;
`else
  assign tail_state = DONE;
`endif

  loader_word_assembler u_word_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (state != DATA),
    .byte_valid (accept && (state == DATA)),
    .byte_data  (rx_data),
    .word_ready (word_ready),
    .word_full  (word_full)
  );

  // State register; outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      rx_ready         <= 1'b0;
      mem_write_enable <= 1'b0;
      cpu_hold         <= 1'b1;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
      mem_byte_address <= BASE_ADDR;
      mem_write_data   <= '0;
    end else begin
      state            <= state_nxt;
      rx_ready         <= rx_ready_nxt;
      mem_write_enable <= we_nxt;
      cpu_hold         <= hold_nxt;
      load_done        <= done_nxt;
      load_error       <= error_nxt;
      if (word_ready) begin
        mem_byte_address <= BASE_ADDR + (32'(word_idx) << 2);
        mem_write_data   <= word_full;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = LEN_LO;
      LEN_LO: if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len == '0)                         state_nxt = tail_state;
          else if (32'(len) > 32'(MEM_WORDS))    state_nxt = ERROR;
          else                                   state_nxt = DATA;
        end
      end
      DATA:   if (word_ready) state_nxt = WRITE;
      WRITE:  state_nxt = ((word_idx + 16'd1) == count) ? tail_state : DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK:    if (accept) state_nxt = (rx_data == csum) ? DONE : ERROR;
`else
      CHK:    state_nxt = DONE;
`endif
      DONE, ERROR: if (start) state_nxt = LEN_LO;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready_nxt = state_nxt inside {LEN_LO, LEN_HI, DATA, CHK};
    we_nxt       = (state_nxt == WRITE);
    hold_nxt     = (state_nxt != DONE);
    done_nxt     = (state_nxt == DONE);
    error_nxt    = (state_nxt == ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      word_idx <= '0;
    end else begin
      if (state == LEN_LO && accept) count[7:0] <= rx_data;
      if (state == LEN_HI && accept) begin
        count[15:8] <= rx_data;
        word_idx    <= '0;
      end
      if (state == WRITE) word_idx <= word_idx + 16'd1;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR covers data bytes only; the header resets it.
  always_ff @(posedge clk) begin
    if (state == LEN_HI && accept) csum <= '0;
    else if (state == DATA && accept) csum <= csum ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as images are
// streamed and popped as write strobes appear.
`timescale 1ns/1ps
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] mem_byte_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int          n_checks = 0;
  int          n_pass = 0;
  int          write_count = 0;
  int          wc0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        prev_we = 1'b0;
  logic [31:0] img[$];

  program_loader #(.MEM_WORDS(256), .BASE_ADDR(BASE)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .mem_byte_address (mem_byte_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .cpu_hold         (cpu_hold),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n && mem_write_enable) begin
      write_count++;
      check("we_single_cycle", 64'(prev_we), 64'd0);
      check("hold_during_write", 64'(cpu_hold), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(mem_byte_address), 64'(mon_e[63:32]));
        check("wr_data", 64'(mem_write_data), 64'(mon_e[31:0]));
      end
    end
    prev_we = mem_write_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    rx_valid = 1'b0;
    if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (!(load_done || load_error) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(load_done || load_error)) check("end_timeout", 64'(n), 64'd0);
  endtask

  task automatic load_image(input int gap);
    logic [7:0]  cs;
    logic [31:0] w;
    int          sz;
    cs = 8'h00;
    sz = img.size();
    for (int i = 0; i < sz; i++) exp_q.push_back({BASE + 32'(i * 4), img[i]});
    pulse_start();
    send_byte(sz[7:0], gap);
    send_byte(sz[15:8], gap);
    for (int i = 0; i < sz; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], gap);
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(cs, gap);
`endif
    wait_end();
  endtask

  task automatic check_done(input int exp_writes);
    check("done_flag", 64'(load_done), 64'd1);
    check("done_hold", 64'(cpu_hold), 64'd0);
    check("done_err", 64'(load_error), 64'd0);
    check("done_rx_ready", 64'(rx_ready), 64'd0);
    check("done_writes", 64'(write_count - wc0), 64'(exp_writes));
    check("done_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_we", 64'(mem_write_enable), 64'd0);
    check("rst_addr", 64'(mem_byte_address), 64'(BASE));
    check("rst_data", 64'(mem_write_data), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_error), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (2) tick();
    check_reset_outputs();
    reset_n = 1'b1;
    tick();

    // Reference two-word image, back-to-back bytes
    img = '{32'h0030_0113, 32'h0050_0093};
    wc0 = write_count;
    load_image(0);
    check_done(2);

    // Zero-length image
    img.delete();
    wc0 = write_count;
    load_image(0);
    check_done(0);

    // Oversized count 257, then recovery with a valid image
    wc0 = write_count;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    wait_end();
    check("big_err", 64'(load_error), 64'd1);
    check("big_hold", 64'(cpu_hold), 64'd1);
    check("big_done", 64'(load_done), 64'd0);
    check("big_rx_ready", 64'(rx_ready), 64'd0);
    check("big_writes", 64'(write_count - wc0), 64'd0);
    img = '{$urandom(), $urandom()};
    wc0 = write_count;
    load_image(0);
    check_done(2);

    // Random rx_valid gaps
    img = '{32'h0030_0113, 32'h0050_0093};
    wc0 = write_count;
    load_image(3);
    check_done(2);
    img = '{$urandom(), $urandom(), $urandom(), 32'hFFFF_FFFF};
    wc0 = write_count;
    load_image(4);
    check_done(4);

    // Reset after 5 data bytes of a 3-word image
    wc0 = write_count;
    exp_q.push_back({BASE, 32'hA1B2_C3D4});
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'hD4, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hA1, 0);
    send_byte(8'h55, 0);
    pulse_start();
    @(negedge clk);
    check("mid_start_ignored_ready", 64'(rx_ready), 64'd1);
    check("mid_start_ignored_done", 64'(load_done), 64'd0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    check("mid_writes", 64'(write_count - wc0), 64'd1);
    check("mid_q_empty", 64'(exp_q.size()), 64'd0);
    reset_n = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (3) @(negedge clk);
    check("idle_rx_ready", 64'(rx_ready), 64'd0);
    rx_valid = 1'b0;
    tick();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img = '{32'h0000_0013};
    wc0 = write_count;
    load_image(0);
    check_done(1);
    wc0 = write_count;
    exp_q.push_back({BASE, 32'h0000_0013});
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    wait_end();
    check("csum_bad_err", 64'(load_error), 64'd1);
    check("csum_bad_hold", 64'(cpu_hold), 64'd1);
    check("csum_bad_writes", 64'(write_count - wc0), 64'd1);
    check("csum_bad_q_empty", 64'(exp_q.size()), 64'd0);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the instruction memory.
- Accepts a byte stream (from the UART receiver) over a valid/ready handshake and parses a 2-byte little-endian word count followed by that many little-endian 32-bit instructions.
- Drives the program memory write port (byte address, write enable, write data) and holds the CPU until the image is complete.

Parameters:
- MEM_WORDS, 256, instruction memory depth in 32-bit words; maximum accepted word count.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  single-cycle request to begin a load
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts the byte this cycle
- mem_byte_address  output  32  write byte address to program memory
- mem_write_enable  output  1  one-cycle write strobe
- mem_write_data  output  32  instruction word
- cpu_hold  output  1  keeps the core stalled/in reset while high
- load_done  output  1  image fully written
- load_error  output  1  load aborted

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - cpu_hold=1; rx_ready=0; mem_write_enable=0; mem_byte_address=BASE_ADDR; mem_write_data=0; load_done=0; load_error=0.
- Outputs: all registered. A byte is accepted on a cycle where rx_valid&&rx_ready.
- States:
  - IDLE: rx_ready=0. start goes to LEN_LO and clears load_done/load_error.
  - LEN_LO: rx_ready=1. Accepted byte becomes count[7:0].
  - LEN_HI: rx_ready=1. Accepted byte becomes count[15:8].
    - count==0 goes to DONE (or CHK when the optional feature is enabled).
    - count>MEM_WORDS goes to ERROR; no write is issued.
    - Otherwise goes to DATA with word_idx=0 and byte_idx=0.
  - DATA: rx_ready=1. Accepted byte goes to word[8*byte_idx+:8] (first byte is bits 7:0). byte_idx increments. The 4th byte goes to WRITE.
  - WRITE: rx_ready=0. Drives, for exactly one cycle:
    - mem_write_enable=1
    - mem_byte_address=BASE_ADDR+(word_idx<<2)
    - mem_write_data=assembled word
    Then word_idx increments. If word_idx+1==count, go to DONE (or CHK); else go to DATA.
    - Write strobe is asserted the cycle after the 4th byte is accepted.
  - DONE: cpu_hold=0, load_done=1, rx_ready=0.
  - ERROR: cpu_hold=1, load_error=1, rx_ready=0.
- Restart: start in DONE or ERROR re-enters LEN_LO, sets cpu_hold=1, and clears the flags.
- start in LEN_LO, LEN_HI, DATA, WRITE or CHK is ignored.
- rx_valid while rx_ready=0 is not consumed; the source must hold the byte.
- rx_valid low mid-word stalls indefinitely, with no timeout.
- Reset mid-load returns to IDLE with cpu_hold=1. Words already written stay in memory; no rollback.
- word_idx is 16 bits wide. Address arithmetic is 32-bit and wraps modulo 2^32 (unreachable when count≤MEM_WORDS).
- mem_byte_address and mem_write_data hold their last values when not writing.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every data byte (header excluded) is maintained.
  - After the last WRITE, state CHK (rx_ready=1) accepts one checksum byte.
  - Match goes to DONE; mismatch goes to ERROR. Already-written words stay in memory and cpu_hold stays 1.
- Undefined: there is no CHK state; the last WRITE goes straight to DONE, and no checksum byte is consumed.

Decomposition:
- Shared package program_loader_pkg:
  - State enum loader_state_t (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERROR).
  - Constants BYTES_PER_WORD=4 and HDR_BYTES=2.
- One natural sub-module: loader_word_assembler (byte_idx counter plus little-endian shift register, with a word_ready pulse). The FSM stays in program_loader.

Test Plan:
- Reset, then stream 02 00 | 13 01 30 00 | 93 00 50 00 -> writes 32'h00300113 @0x0 and 32'h00500093 @0x4, one strobe each; load_done=1; cpu_hold=0.
- Count 00 00 -> DONE directly; no mem_write_enable pulse; rx_ready drops after the 2nd byte.
- Count 01 01 (257) with MEM_WORDS=256 -> ERROR; load_error=1; cpu_hold=1; zero writes; then start plus a valid image -> DONE.
- Random rx_valid gaps, including rx_valid asserted during WRITE -> the byte is not consumed that cycle; written data is identical to the gap-free run.
- reset_n=0 after 5 data bytes of a 3-word image -> one write occurred; outputs return to reset values; state IDLE.
- With PROGRAM_LOADER_CHECKSUM_EN: image 01 00 | 13 00 00 00 | checksum 13 -> DONE; checksum 12 -> ERROR with the word at 0x0 still written.
